// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sharing of the single-port memory_controller between
// the evaluator (port 0) and allocator/GC (port 1), one transaction in flight.
module memory_arbiter #(
   parameter int ADDR_WIDTH   = 6,
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                boot_done,
   input  logic [1:0]                          req_valid,
   output logic [1:0]                          req_ready,
   input  logic [1:0]                          req_write,
   input  logic [1:0][ADDR_WIDTH-1:0]          req_addr,
   input  logic [1:0][DATA_WIDTH-1:0]          req_wdata,
   output logic [1:0]                          rsp_valid,
   output logic [DATA_WIDTH-1:0]               rsp_rdata,
   output logic                                busy,
   output logic                                mem_write_enable,
   output logic [ADDR_WIDTH-1:0]               mem_addr,
   output logic [DATA_WIDTH-1:0]               mem_write_data,
   input  logic [DATA_WIDTH-1:0]               mem_read_data
);
   localparam int CW = $clog2(READ_LATENCY + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t                state_q, state_d;
   logic                  rr_q, rr_d, win_q, win_d, wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  grant, win;
   always_comb begin
      grant     = state_q == IDLE && boot_done && |req_valid;
      win       = &req_valid ? rr_q : req_valid[1];
      req_ready = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
      state_d   = state_q;
      rr_d      = rr_q;
      win_d     = win_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: if (grant) begin
            state_d = ISSUE;
            rr_d    = ~win;
            win_d   = win;
            wr_d    = req_write[win];
            addr_d  = req_addr[win];
            wdata_d = req_wdata[win];
         end
         ISSUE: begin
            state_d = wr_q ? RESP : WAIT;
            cnt_d   = '0;
            if (wr_q) rdata_d = '0;
         end
         // read data is taken on the last of READ_LATENCY cycles spent in WAIT
         WAIT: if (cnt_q == CW'(READ_LATENCY - 1)) begin
            state_d = RESP;
            rdata_d = mem_read_data;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         win_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         win_q   <= win_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end
   assign busy             = state_q != IDLE;
   assign mem_write_enable = state_q == ISSUE && wr_q;
   assign mem_addr         = addr_q;
   assign mem_write_data   = wdata_q;
   assign rsp_valid        = state_q == RESP ? (win_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_rdata        = rdata_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: two builds (READ_LATENCY 1 and 3) checked every cycle against a
// transaction-timing model, plus directed literal checks.
module tb_memory_arbiter;
   localparam logic [7:0] TYPE_NUMBER = 8'h01;
   logic clk = 1'b0, rst = 1'b1, boot = 1'b0;
   logic [1:0]      rv [2], rw [2], rdy [2], rsp [2];
   logic [1:0][5:0] ra [2];
   logic [1:0][7:0] rwd [2];
   logic [7:0]      rdat [2], mwd [2], mrd [2];
   logic [5:0]      ma [2];
   logic            we [2], bsy [2];
   logic [7:0]      env_mem [2][64] = '{default: '0};
   logic [7:0]      ref_mem [2][64] = '{default: '0};
   logic [7:0]      pipe [2][3];
   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   memory_arbiter #(.READ_LATENCY(1)) dut0 (
      .clk(clk), .rst(rst), .boot_done(boot), .req_valid(rv[0]), .req_ready(rdy[0]),
      .req_write(rw[0]), .req_addr(ra[0]), .req_wdata(rwd[0]), .rsp_valid(rsp[0]),
      .rsp_rdata(rdat[0]), .busy(bsy[0]), .mem_write_enable(we[0]), .mem_addr(ma[0]),
      .mem_write_data(mwd[0]), .mem_read_data(mrd[0]));
   memory_arbiter #(.READ_LATENCY(3)) dut1 (
      .clk(clk), .rst(rst), .boot_done(boot), .req_valid(rv[1]), .req_ready(rdy[1]),
      .req_write(rw[1]), .req_addr(ra[1]), .req_wdata(rwd[1]), .rsp_valid(rsp[1]),
      .rsp_rdata(rdat[1]), .busy(bsy[1]), .mem_write_enable(we[1]), .mem_addr(ma[1]),
      .mem_write_data(mwd[1]), .mem_read_data(mrd[1]));

   // memory controller stand-ins, read data arriving READ_LATENCY cycles after the address
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (we[d]) env_mem[d][ma[d]] <= mwd[d];
         pipe[d][0] <= env_mem[d][ma[d]];
         pipe[d][1] <= pipe[d][0];
         pipe[d][2] <= pipe[d][1];
      end
   end
   assign mrd[0] = pipe[0][0];
   assign mrd[1] = pipe[1][2];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, want);
      end
   endtask

   // model: each granted transaction owns the memory until its response cycle
   int cyc = 0, free_at [2], we_at [2], rsp_at [2];
   logic armed = 1'b0;
   logic rr [2], rsp_port [2];
   logic [5:0] la [2];
   logic [7:0] lw [2], rsp_dat [2];
   always @(negedge clk) begin
      logic g, w;
      logic [1:0] er, es;
      for (int d = 0; d < 2; d++) begin
         g  = cyc >= free_at[d] && boot && |rv[d];
         w  = rv[d] == 2'b11 ? rr[d] : rv[d][1];
         er = g ? (w ? 2'b10 : 2'b01) : 2'b00;
         es = cyc == rsp_at[d] ? (rsp_port[d] ? 2'b10 : 2'b01) : 2'b00;
         if (armed) begin
            chk($sformatf("dut%0d req_ready", d), rdy[d], er);
            chk($sformatf("dut%0d busy", d), bsy[d], cyc < free_at[d]);
            chk($sformatf("dut%0d mem_write_enable", d), we[d], cyc == we_at[d]);
            chk($sformatf("dut%0d mem_addr", d), ma[d], la[d]);
            chk($sformatf("dut%0d mem_write_data", d), mwd[d], lw[d]);
            chk($sformatf("dut%0d rsp_valid", d), rsp[d], es);
            if (es != 0) chk($sformatf("dut%0d rsp_rdata", d), rdat[d], rsp_dat[d]);
         end
         if (rst) begin
            free_at[d] = cyc + 1;
            we_at[d]   = -1;
            rsp_at[d]  = -1;
            rr[d]      = 1'b0;
            la[d]      = '0;
            lw[d]      = '0;
         end else if (g) begin
            rr[d]       = ~w;
            la[d]       = ra[d][w];
            lw[d]       = rwd[d][w];
            rsp_port[d] = w;
            if (rw[d][w]) begin
               we_at[d]          = cyc + 1;
               rsp_at[d]         = cyc + 2;
               rsp_dat[d]        = '0;
               ref_mem[d][la[d]] = lw[d];
            end else begin
               we_at[d]   = -1;
               rsp_at[d]  = cyc + 2 + (d == 1 ? 3 : 1);
               rsp_dat[d] = ref_mem[d][la[d]];
            end
            free_at[d] = rsp_at[d] + 1;
         end
      end
      if (rst) armed = 1'b1;
      cyc++;
   end

   task automatic wait_grant(int d, int p);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!rdy[d][p] && k < 40);
      if (!rdy[d][p]) begin
         n_cmp++;
         n_bad++;
         $display("FAIL grant timeout dut%0d port%0d", d, p);
      end
   endtask

   task automatic xact(int d, int p, logic wr, logic [5:0] a, logic [7:0] wd, logic [7:0] rd);
      int k = 0;
      @(posedge clk);
      #1;
      rw[d][p]  = wr;
      ra[d][p]  = a;
      rwd[d][p] = wd;
      rv[d][p]  = 1'b1;
      wait_grant(d, p);
      chk("idle at grant", bsy[d], 0);
      @(posedge clk);
      #1 rv[d][p] = 1'b0;
      do begin
         @(negedge clk);
         k++;
         chk("busy in flight", bsy[d], 1);
         if (k == 1) chk("issue write enable", we[d], wr);
         if (k == 1 && wr) chk("issue addr/data", {ma[d], mwd[d]}, {a, wd});
      end while (rsp[d] == 0 && k < 20);
      chk("rsp latency", k, wr ? 2 : (d == 1 ? 5 : 3));
      chk("rsp port", rsp[d], p ? 2 : 1);
      chk("rsp rdata", rdat[d], rd);
      @(negedge clk);
      chk("idle after rsp", bsy[d], 0);
   endtask

   initial begin
      int gseq [4];
      int ng = 0;
      for (int d = 0; d < 2; d++) begin
         rv[d] = '0; rw[d] = '0; ra[d] = '0; rwd[d] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset outputs", {rdy[0], rsp[0], rdat[0], bsy[0], we[0], ma[0], mwd[0]}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rv[0][0] = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("boot hold ready", rdy[0], 0);
         chk("boot hold mem we", we[0], 0);
      end
      @(posedge clk);
      #1 boot = 1'b1;
      @(negedge clk);
      chk("boot release grant", rdy[0], 2'b01);
      @(posedge clk);
      #1 rv[0][0] = 1'b0;
      repeat (4) @(posedge clk);
      xact(0, 0, 1'b1, 6'h01, 8'h2A, 8'h00);
      xact(0, 0, 1'b1, 6'h00, TYPE_NUMBER, 8'h00);
      xact(0, 1, 1'b0, 6'h01, 8'h00, 8'h2A);
      @(posedge clk);
      #1;
      rw[0] = 2'b00;
      ra[0][0] = 6'h00;
      ra[0][1] = 6'h01;
      rv[0] = 2'b11;
      for (int k = 0; k < 60 && ng < 4; k++) begin
         @(negedge clk);
         if (rdy[0] != 0) gseq[ng++] = int'(rdy[0][1]);
         if (rsp[0] != 0) chk("rr rdata", rdat[0], rsp[0][1] ? 8'h2A : TYPE_NUMBER);
      end
      @(posedge clk);
      #1 rv[0] = 2'b00;
      chk("rr grant count", ng, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("rr grant %0d", i), gseq[i], i % 2);
      repeat (6) @(posedge clk);
      #1;
      ra[0][0] = 6'h01;
      rv[0][0] = 1'b1;
      wait_grant(0, 0);
      @(posedge clk);
      #1 rv[0][0] = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("busy in wait", bsy[0], 1);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post-rst outputs", {rdy[0], rsp[0], rdat[0], bsy[0], we[0], ma[0], mwd[0]}, 0);
      repeat (5) begin
         @(negedge clk);
         chk("dropped rsp", rsp[0], 0);
      end
      xact(0, 0, 1'b0, 6'h01, 8'h00, 8'h2A);
      xact(1, 0, 1'b1, 6'h01, 8'h2A, 8'h00);
      xact(1, 1, 1'b0, 6'h01, 8'h00, 8'h2A);
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
